// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dino_pkg
// Description : Shared definitions for the obstacle scroller. Holds the
//               obstacle line width, the LFSR seed, the game state
//               encoding and the LFSR next-state function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dino_pkg;

  localparam int         LINE_W    = 8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1: taps on bits 7,5,4,3,
  // shifted toward the MSB with the feedback bit entering at bit 0.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_scroller_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : Free-running 8-bit Fibonacci LFSR used as the obstacle
//               spawn random source. Advances every clock; only reset
//               returns it to the seed.
// Ports       : clk   - system clock (rising edge)
//               reset - asynchronous active-high reset, loads LFSR_SEED
//               q     - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr8_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/obstacle_scroller.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_scroller
// Description : Scrolls a line of obstacles toward the dino column. A
//               divider produces a scroll tick every "period" clocks; on
//               each tick the line shifts up by one and a new obstacle may
//               enter at bit 0, subject to a minimum gap. Obstacles leaving
//               bit 7 without a collision add to a saturating score.
//               Optional macro OBSTACLE_SPEEDUP_EN: period halves at score
//               16 and again at 32 (floor TICK_DIV/4). Without it the
//               period is TICK_DIV.
// Ports       : clk           - system clock (rising edge)
//               reset         - asynchronous active-high reset
//               start         - level; starts/restarts a game from IDLE/HALT
//               collision     - registered hit flag, honoured in RUN only
//               obstacle_line - obstacle map, bit 7 dino column, bit 0 entry
//               tick          - registered pulse marking a scroll step
//               score         - obstacles passed, saturating at 8'hFF
//               running       - high while in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_scroller
  import dino_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int MIN_GAP  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              collision,
  output logic [LINE_W-1:0] obstacle_line,
  output logic              tick,
  output logic [7:0]        score,
  output logic              running
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int PER_W = DIV_W + 1;
  localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  localparam logic [PER_W-1:0] PERIOD_BASE = PER_W'(TICK_DIV);
  localparam logic [GAP_W-1:0] GAP_MAX     = GAP_W'(MIN_GAP);

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q,  line_d;
  logic [7:0]          score_q, score_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic [GAP_W-1:0]    gap_q,   gap_d;
  logic                tick_q,  tick_d;

  logic [7:0]          lfsr_q;
  logic                lfsr_unused;
  logic                spawn;
  logic [PER_W-1:0]    period_d;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Only bit 0 drives the spawn decision; the rest stays visible on lfsr_q.
  assign lfsr_unused = ^lfsr_q[7:1];

  assign spawn = lfsr_q[0] && (gap_q >= GAP_MAX);

  // Period follows the score the next cycle will hold. Score only moves on
  // a tick edge, where the divider restarts, so the divider never overruns
  // a shrinking period.
`ifdef OBSTACLE_SPEEDUP_EN
  logic [1:0] shift_amt;
  always_comb begin
    shift_amt = (score_d[7:5] != 3'b000) ? 2'd2 : {1'b0, score_d[4]};
    period_d  = PERIOD_BASE >> shift_amt;
  end
`else
  assign period_d = PERIOD_BASE;
`endif

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    score_d = score_q;
    div_d   = div_q;
    gap_d   = gap_q;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          line_d  = '0;
          score_d = '0;
          div_d   = '0;
          gap_d   = '0;
        end
      end
      RUN: begin
        if (collision) begin
          // Hit wins over any scroll step in the same cycle.
          state_d = HALT;
        end else if (tick_q) begin
          line_d = {line_q[LINE_W-2:0], spawn};
          div_d  = '0;
          if (spawn) begin
            gap_d = '0;
          end else if (gap_q < GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
          end
          if (line_q[LINE_W-1] && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered tick: high exactly while the divider sits at period-1.
    tick_d = (state_d == RUN) && ({1'b0, div_d} == (period_d - PER_W'(1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      score_q <= '0;
      div_q   <= '0;
      gap_q   <= GAP_MAX;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      score_q <= score_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      tick_q  <= tick_d;
    end
  end

  assign obstacle_line = line_q;
  assign tick          = tick_q;
  assign score         = score_q;
  assign running       = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_scroller
// Description : Directed self-checking bench for obstacle_scroller. Main
//               instance uses TICK_DIV=4, MIN_GAP=3; a second instance with
//               MIN_GAP=2 is used to build line 8'h24 before a mid-game
//               reset. Spawn randomness is pinned by forcing the LFSR word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_scroller;
  import dino_pkg::*;

`ifdef OBSTACLE_SPEEDUP_EN
  localparam int EXP_P16 = 2;
  localparam int EXP_P32 = 1;
`else
  localparam int EXP_P16 = 4;
  localparam int EXP_P32 = 4;
`endif

  logic       clk;
  logic       reset, start, collision;
  logic [7:0] line, score;
  logic       tick, running;

  logic       reset2, start2, collision2;
  logic [7:0] line2, score2;
  logic       tick2, running2;

  int n_checks = 0;
  int n_pass   = 0;

  obstacle_scroller #(.TICK_DIV(4), .MIN_GAP(3)) dut (
    .clk(clk), .reset(reset), .start(start), .collision(collision),
    .obstacle_line(line), .tick(tick), .score(score), .running(running)
  );

  obstacle_scroller #(.TICK_DIV(4), .MIN_GAP(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .collision(collision2),
    .obstacle_line(line2), .tick(tick2), .score(score2), .running(running2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // Waits (at negedges) until tick is high; leaves the bench in the tick cycle.
  task automatic wait_tick(output int waited);
    waited = 0;
    while (tick !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (tick !== 1'b1) begin
      n_checks++;
      $error("FAIL tick_timeout: observed no tick in %0d clocks, required a tick", waited);
    end
  endtask

  // Completes one scroll step; period is clocks from previous step to this one.
  task automatic next_tick(output int period);
    int w;
    wait_tick(w);
    period = w + 1;
    @(negedge clk);
  endtask

  logic [7:0] exp_line [0:15] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h11,
                                  8'h22, 8'h44, 8'h88, 8'h11, 8'h22, 8'h44, 8'h88, 8'h11};
  logic [7:0] exp_scr  [0:15] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                                  8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};

  initial begin
    int   per;
    int   prev;
    bit   seen15, seen16, seen32;

    reset = 1'b1; start = 1'b0; collision = 1'b0;
    reset2 = 1'b1; start2 = 1'b0; collision2 = 1'b0;
    seen15 = 1'b0; seen16 = 1'b0; seen32 = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    check("rst_line",    line,        8'h00);
    check("rst_score",   score,       8'h00);
    check("rst_tick",    tick,        1'b0);
    check("rst_running", running,     1'b0);
    check("rst_lfsr",    dut.lfsr_q,  8'hA5);
    reset = 1'b0; reset2 = 1'b0;

    // ---- LFSR free-runs in IDLE; collision ignored outside RUN ----
    collision = 1'b1;
    @(negedge clk);
    check("lfsr_step1", dut.lfsr_q, 8'h4A);
    @(negedge clk);
    check("lfsr_step2", dut.lfsr_q, 8'h95);
    @(negedge clk);
    check("lfsr_step3", dut.lfsr_q, 8'h2A);
    check("idle_running", running, 1'b0);
    check("idle_tick",    tick,    1'b0);
    collision = 1'b0;

    // ---- scrolling and gap rule with every LFSR bit forced high ----
    force dut.lfsr_q = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_running", running, 1'b1);
    check("start_line",    line,    8'h00);
    for (int i = 0; i < 16; i++) begin
      next_tick(per);
      check("scroll_period", per,   4);
      check("scroll_line",   line,  exp_line[i]);
      check("scroll_score",  score, exp_scr[i]);
      if (i == 3) start = 1'b1;   // start held during RUN must be ignored
    end
    start = 1'b0;

    // ---- build 8'h81: six empty steps, then one spawn ----
    force dut.lfsr_q = 8'h00;
    repeat (6) next_tick(per);
    force dut.lfsr_q = 8'hFF;
    next_tick(per);
    check("pre_hit_line",  line,  8'h81);
    check("pre_hit_score", score, 8'd3);

    // ---- collision in a tick cycle wins ----
    wait_tick(per);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    check("hit_line",    line,    8'h81);
    check("hit_score",   score,   8'd3);
    check("hit_running", running, 1'b0);
    check("hit_tick",    tick,    1'b0);
    repeat (8) begin
      collision = ~collision;
      @(negedge clk);
    end
    collision = 1'b0;
    check("halt_line",  line,  8'h81);
    check("halt_score", score, 8'd3);
    check("halt_tick",  tick,  1'b0);

    // ---- restart from HALT clears the game ----
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_running", running, 1'b1);
    check("restart_line",    line,    8'h00);
    check("restart_score",   score,   8'h00);

    // ---- long run: period vs score, then saturation ----
    for (int i = 0; i < 1500 && score !== 8'hFF; i++) begin
      prev = score;
      next_tick(per);
      if (prev == 15 && !seen15) begin seen15 = 1'b1; check("period_s15", per, 4);       end
      if (prev == 16 && !seen16) begin seen16 = 1'b1; check("period_s16", per, EXP_P16); end
      if (prev == 32 && !seen32) begin seen32 = 1'b1; check("period_s32", per, EXP_P32); end
    end
    check("score_sat", score, 8'hFF);
    repeat (8) next_tick(per);
    check("score_hold", score, 8'hFF);
    release dut.lfsr_q;

    // ---- mid-game asynchronous reset with line 8'h24 (MIN_GAP=2 instance) ----
    force dut2.lfsr_q = 8'hFF;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (32) @(negedge clk);
    check("pre_rst_line2",    line2,    8'h24);
    check("pre_rst_running2", running2, 1'b1);
    release dut2.lfsr_q;
    #2 reset2 = 1'b1;
    #1;
    check("arst_line2",    line2,       8'h00);
    check("arst_score2",   score2,      8'h00);
    check("arst_tick2",    tick2,       1'b0);
    check("arst_running2", running2,    1'b0);
    check("arst_state2",   dut2.state_q, IDLE);
    check("arst_lfsr2",    dut2.lfsr_q, 8'hA5);
    @(negedge clk);
    reset2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("rerun_running2", running2, 1'b1);
    check("rerun_line2",    line2,    8'h00);
    check("rerun_tick2",    tick2,    1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
